ble_button_parser: RTL and testbench

- Sits between `uart_rx` (BLE UART byte stream) and `gameplay` (`user_input`/`user_rdy`).
- Parses Bluefruit control-pad packets of 5 bytes: '!' 'B' <btn '1'..'8'> <'1' press / '0' release> <checksum>.
- Emits one validated command pulse per good packet and maintains a held-button mask.
- Detects malformed, checksum-failed and stalled packets, flags them, and resynchronises automatically.

---
 rtl/ble_pkg.sv | 24 ++
 rtl/ble_button_parser.sv | 187 ++++++++++++++++++
 tb/tb_ble_button_parser.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ble_pkg.sv
// Shared definitions for the Bluefruit control-pad parser and its consumers.
// gameplay imports this package to decode cmd_out.
package ble_pkg;

  typedef enum logic [2:0] {
    BLE_IDLE      = 3'd0,
    BLE_GOT_BANG  = 3'd1,
    BLE_GOT_TYPE  = 3'd2,
    BLE_GOT_BTN   = 3'd3,
    BLE_GOT_STATE = 3'd4
  } ble_state_t;

  localparam logic [7:0] BLE_BANG     = 8'h21;
  localparam logic [7:0] BLE_TYPE_BTN = 8'h42;
  localparam logic [7:0] ASCII_ZERO   = 8'h30;
  localparam logic [7:0] ASCII_ONE    = 8'h31;
  localparam logic [7:0] ASCII_EIGHT  = 8'h38;

  // The trailing packet byte is the one's complement of the 8-bit header sum.
  function automatic logic [7:0] ble_checksum(input logic [7:0] sum);
    return ~sum;
  endfunction

endpackage

// File: rtl/ble_button_parser.sv
// Parses 5-byte Bluefruit button packets from the BLE UART into command pulses,
// a held-button mask and error reporting with automatic resynchronisation.
module ble_button_parser
  import ble_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [7:0]           data_in,
  input  logic                 valid_in,
  output logic [7:0]           cmd_out,
  output logic                 cmd_valid_out,
  output logic [3:0]           button_id_out,
  output logic                 pressed_out,
  output logic [7:0]           buttons_held_out,
  output logic                 err_out,
  output logic [ERR_CNT_W-1:0] err_count_out
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX    = {ERR_CNT_W{1'b1}};

  ble_state_t           state_r, state_nxt_s;
  logic [7:0]           sum_r, sum_nxt_s;
  logic [3:0]           id_r, id_nxt_s;
  logic                 pressed_r, pressed_nxt_s;
  logic [TIMER_W-1:0]   timer_r;
  logic                 timeout_s;
  logic                 good_s;
  logic                 err_s;
  logic [7:0]           held_mask_s;

  logic [7:0]           cmd_r;
  logic                 cmd_valid_r;
  logic [3:0]           button_id_r;
  logic                 pressed_out_r;
  logic [7:0]           held_r;
  logic                 err_r;
  logic [ERR_CNT_W-1:0] err_count_r;

  assign held_mask_s = 8'd1 << (id_r - 4'd1);

  // Packet FSM next state; a '!' anywhere before the checksum restarts the packet.
  always_comb begin
    state_nxt_s   = state_r;
    sum_nxt_s     = sum_r;
    id_nxt_s      = id_r;
    pressed_nxt_s = pressed_r;
    good_s        = 1'b0;
    err_s         = 1'b0;
    timeout_s     = (state_r != BLE_IDLE) && (timer_r == TIMER_LAST);
    if (valid_in) begin
      case (state_r)
        BLE_IDLE: begin
          if (data_in == BLE_BANG) begin
            state_nxt_s = BLE_GOT_BANG;
            sum_nxt_s   = BLE_BANG;
          end else begin
            state_nxt_s = BLE_IDLE;
          end
        end
        BLE_GOT_BANG: begin
          if (data_in == BLE_TYPE_BTN) begin
            state_nxt_s = BLE_GOT_TYPE;
            sum_nxt_s   = sum_r + data_in;
          end else if (data_in == BLE_BANG) begin
            state_nxt_s = BLE_GOT_BANG;
            sum_nxt_s   = BLE_BANG;
            err_s       = 1'b1;
          end else begin
            // Other packet types (colour, quaternion...) are not ours to flag.
            state_nxt_s = BLE_IDLE;
          end
        end
        BLE_GOT_TYPE: begin
          if ((data_in >= ASCII_ONE) && (data_in <= ASCII_EIGHT)) begin
            state_nxt_s = BLE_GOT_BTN;
            sum_nxt_s   = sum_r + data_in;
            id_nxt_s    = data_in[3:0];
          end else if (data_in == BLE_BANG) begin
            state_nxt_s = BLE_GOT_BANG;
            sum_nxt_s   = BLE_BANG;
            err_s       = 1'b1;
          end else begin
            state_nxt_s = BLE_IDLE;
            err_s       = 1'b1;
          end
        end
        BLE_GOT_BTN: begin
          if ((data_in == ASCII_ZERO) || (data_in == ASCII_ONE)) begin
            state_nxt_s   = BLE_GOT_STATE;
            sum_nxt_s     = sum_r + data_in;
            pressed_nxt_s = data_in[0];
          end else if (data_in == BLE_BANG) begin
            state_nxt_s = BLE_GOT_BANG;
            sum_nxt_s   = BLE_BANG;
            err_s       = 1'b1;
          end else begin
            state_nxt_s = BLE_IDLE;
            err_s       = 1'b1;
          end
        end
        BLE_GOT_STATE: begin
          state_nxt_s = BLE_IDLE;
          if (data_in == ble_checksum(sum_r)) begin
            good_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end
        default: begin
          state_nxt_s = BLE_IDLE;
        end
      endcase
    end else if (timeout_s) begin
      state_nxt_s = BLE_IDLE;
      err_s       = 1'b1;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM, header accumulator and inter-byte timer.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r   <= BLE_IDLE;
      sum_r     <= 8'h00;
      id_r      <= 4'h0;
      pressed_r <= 1'b0;
      timer_r   <= {TIMER_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      sum_r     <= sum_nxt_s;
      id_r      <= id_nxt_s;
      pressed_r <= pressed_nxt_s;
      if (valid_in || (state_nxt_s == BLE_IDLE)) begin
        timer_r <= {TIMER_W{1'b0}};
      end else begin
        timer_r <= timer_r + TIMER_W'(1);
      end
    end
  end

  // Registered command, held mask and error reporting.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cmd_r         <= 8'h00;
      cmd_valid_r   <= 1'b0;
      button_id_r   <= 4'h0;
      pressed_out_r <= 1'b0;
      held_r        <= 8'h00;
      err_r         <= 1'b0;
      err_count_r   <= {ERR_CNT_W{1'b0}};
    end else begin
      cmd_valid_r <= good_s;
      err_r       <= err_s;
      if (good_s) begin
        cmd_r         <= {pressed_r, 3'b000, id_r};
        button_id_r   <= id_r;
        pressed_out_r <= pressed_r;
        held_r        <= pressed_r ? (held_r | held_mask_s) : (held_r & ~held_mask_s);
      end else begin
        cmd_r         <= cmd_r;
        button_id_r   <= button_id_r;
        pressed_out_r <= pressed_out_r;
        held_r        <= held_r;
      end
      if (err_s && (err_count_r != ERR_MAX)) begin
        err_count_r <= err_count_r + ERR_CNT_W'(1);
      end else begin
        err_count_r <= err_count_r;
      end
    end
  end

  assign cmd_out          = cmd_r;
  assign cmd_valid_out    = cmd_valid_r;
  assign button_id_out    = button_id_r;
  assign pressed_out      = pressed_out_r;
  assign buttons_held_out = held_r;
  assign err_out          = err_r;
  assign err_count_out    = err_count_r;

endmodule

// File: tb/tb_ble_button_parser.sv
// Randomised and directed bench for ble_button_parser against a packet-level model.
module tb_ble_button_parser;

  localparam int T = 40;
  typedef logic [7:0] byte_q_t[$];

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic [7:0] cmd_out;
  logic       cmd_valid_out;
  logic [3:0] button_id_out;
  logic       pressed_out;
  logic [7:0] buttons_held_out;
  logic       err_out;
  logic [7:0] err_count_out;

  int n_chk = 0;
  int n_err = 0;

  byte_q_t    pkt;
  logic [7:0] m_cmd = 8'h00;
  logic [7:0] m_held = 8'h00;
  int m_count = 0;
  int exp_cmd_n = 0, exp_err_n = 0;
  int obs_cmd_n = 0, obs_err_n = 0;
  int since_byte = 0;

  ble_button_parser #(.TIMEOUT_CYCLES(T), .ERR_CNT_W(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .valid_in(valid_in),
    .cmd_out(cmd_out), .cmd_valid_out(cmd_valid_out), .button_id_out(button_id_out),
    .pressed_out(pressed_out), .buttons_held_out(buttons_held_out),
    .err_out(err_out), .err_count_out(err_count_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (cmd_valid_out === 1'b1) obs_cmd_n++;
    if (err_out === 1'b1) obs_err_n++;
  end

  task automatic m_err();
    exp_err_n++;
    if (m_count < 255) m_count++;
  endtask

  // Packet-level reference: pkt holds the bytes of the packet accepted so far.
  task automatic model_byte(input logic [7:0] b);
    int n;
    logic [7:0] tot;
    logic [3:0] id;
    logic pr;
    n = pkt.size();
    since_byte = 0;
    if (n == 0) begin
      if (b == 8'h21) pkt.push_back(b);
    end else if (n == 1) begin
      if (b == 8'h42) pkt.push_back(b);
      else if (b == 8'h21) begin m_err(); pkt = {b}; end
      else pkt.delete();
    end else if (n == 2 || n == 3) begin
      if ((n == 2 && b >= 8'h31 && b <= 8'h38) || (n == 3 && (b == 8'h30 || b == 8'h31)))
        pkt.push_back(b);
      else if (b == 8'h21) begin m_err(); pkt = {b}; end
      else begin m_err(); pkt.delete(); end
    end else begin
      tot = pkt[0] + pkt[1] + pkt[2] + pkt[3] + b;
      if (tot == 8'hFF) begin
        id = 4'(pkt[2] - 8'h30);
        pr = (pkt[3] == 8'h31);
        m_cmd = {pr, 3'b000, id};
        m_held[int'(id) - 1] = pr;
        exp_cmd_n++;
      end else begin
        m_err();
      end
      pkt.delete();
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    data_in = b;
    valid_in = 1'b1;
    @(posedge clk_in);
    model_byte(b);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic send_seq(input byte_q_t s);
    foreach (s[i]) drive_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      valid_in = 1'b0;
      @(posedge clk_in);
      since_byte++;
      if (pkt.size() != 0 && since_byte == T) begin
        m_err();
        pkt.delete();
      end
      #1;
    end
  endtask

  task automatic settle();
    idle(2);
    @(negedge clk_in);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_in = 1'b1;
    valid_in = 1'b0;
    repeat (n) @(posedge clk_in);
    #1;
    pkt.delete();
    m_cmd = 8'h00; m_held = 8'h00; m_count = 0; since_byte = 0;
  endtask

  function automatic logic [7:0] csum(input logic [7:0] btn, input logic [7:0] st);
    logic [7:0] s;
    s = 8'h21 + 8'h42 + btn + st;
    return 8'hFF - s;
  endfunction

  task automatic test_reset();
    do_reset(3);
    n_chk++; if (cmd_out !== 8'h00) begin n_err++; $display("FAIL reset_cmd: got %h want 00", cmd_out); end
    n_chk++; if (cmd_valid_out !== 1'b0 || err_out !== 1'b0) begin n_err++; $display("FAIL reset_pulses: got cv=%b err=%b want 0 0", cmd_valid_out, err_out); end
    n_chk++; if (buttons_held_out !== 8'h00 || err_count_out !== 8'h00) begin n_err++; $display("FAIL reset_held_cnt: got %h %h want 00 00", buttons_held_out, err_count_out); end
    n_chk++; if (button_id_out !== 4'h0 || pressed_out !== 1'b0) begin n_err++; $display("FAIL reset_id: got %h %b want 0 0", button_id_out, pressed_out); end
    rst_in = 1'b0;
    settle();
  endtask

  task automatic test_press_release();
    send_seq({8'h21, 8'h42, 8'h35, 8'h31, 8'h36});
    settle();
    n_chk++; if (cmd_out !== 8'h85 || cmd_out !== m_cmd) begin n_err++; $display("FAIL press_cmd: got %h want 85 (model %h)", cmd_out, m_cmd); end
    n_chk++; if (button_id_out !== 4'd5 || pressed_out !== 1'b1) begin n_err++; $display("FAIL press_id: got %0d %b want 5 1", button_id_out, pressed_out); end
    n_chk++; if (buttons_held_out !== 8'h10 || err_count_out !== 8'h00) begin n_err++; $display("FAIL press_held: got %h cnt %h want 10 00", buttons_held_out, err_count_out); end
    n_chk++; if (obs_cmd_n !== 1 || obs_cmd_n !== exp_cmd_n) begin n_err++; $display("FAIL press_pulses: got %0d want 1", obs_cmd_n); end
    send_seq({8'h21, 8'h42, 8'h35, 8'h30, 8'h37});
    settle();
    n_chk++; if (cmd_out !== 8'h05 || pressed_out !== 1'b0) begin n_err++; $display("FAIL release_cmd: got %h %b want 05 0", cmd_out, pressed_out); end
    n_chk++; if (buttons_held_out !== 8'h00 || obs_cmd_n !== 2) begin n_err++; $display("FAIL release_held: got %h pulses %0d want 00 2", buttons_held_out, obs_cmd_n); end
  endtask

  task automatic test_bad_checksum();
    send_seq({8'h21, 8'h42, 8'h31, 8'h31, 8'h00});
    settle();
    n_chk++; if (obs_cmd_n !== 2 || obs_err_n !== 1) begin n_err++; $display("FAIL badsum_pulses: got cmd %0d err %0d want 2 1", obs_cmd_n, obs_err_n); end
    n_chk++; if (err_count_out !== 8'd1 || buttons_held_out !== 8'h00) begin n_err++; $display("FAIL badsum_state: got cnt %0d held %h want 1 00", err_count_out, buttons_held_out); end
    send_seq({8'h21, 8'h42, 8'h31, 8'h31, 8'h3A});
    settle();
    n_chk++; if (cmd_out !== 8'h81 || buttons_held_out !== 8'h01) begin n_err++; $display("FAIL badsum_recover: got %h held %h want 81 01", cmd_out, buttons_held_out); end
  endtask

  task automatic test_resync();
    int c0, e0;
    c0 = obs_cmd_n; e0 = obs_err_n;
    send_seq({8'h21, 8'h42, 8'h21, 8'h42, 8'h32, 8'h31, 8'h39});
    settle();
    n_chk++; if (obs_err_n - e0 !== 1 || obs_cmd_n - c0 !== 1) begin n_err++; $display("FAIL resync_pulses: got err %0d cmd %0d want 1 1", obs_err_n - e0, obs_cmd_n - c0); end
    n_chk++; if (button_id_out !== 4'd2 || buttons_held_out !== m_held) begin n_err++; $display("FAIL resync_id: got %0d held %h want 2 %h", button_id_out, buttons_held_out, m_held); end
  endtask

  task automatic test_timeout();
    int first, e0;
    first = -1; e0 = obs_err_n;
    send_seq({8'h21, 8'h42});
    for (int k = 1; k <= T + 4; k++) begin
      idle(1);
      if (err_out === 1'b1 && first < 0) first = k;
    end
    settle();
    n_chk++; if (first !== T) begin n_err++; $display("FAIL timeout_cycle: got %0d want %0d", first, T); end
    n_chk++; if (obs_err_n - e0 !== 1 || err_count_out !== 8'(m_count)) begin n_err++; $display("FAIL timeout_err: got %0d cnt %0d want 1 %0d", obs_err_n - e0, err_count_out, m_count); end
    send_seq({8'h21, 8'h42, 8'h38, 8'h31, csum(8'h38, 8'h31)});
    settle();
    n_chk++; if (buttons_held_out[7] !== 1'b1 || buttons_held_out !== m_held || cmd_out !== 8'h88) begin n_err++; $display("FAIL timeout_next: got %h held %h want 88 %h", cmd_out, buttons_held_out, m_held); end
    // Byte arriving on the timeout cycle is processed instead of timing out.
    e0 = obs_err_n;
    send_seq({8'h21, 8'h42, 8'h33});
    idle(T - 1);
    send_seq({8'h30, csum(8'h33, 8'h30)});
    settle();
    n_chk++; if (obs_err_n !== e0 || cmd_out !== 8'h03) begin n_err++; $display("FAIL timeout_edge: got err %0d cmd %h want 0 03", obs_err_n - e0, cmd_out); end
  endtask

  task automatic test_foreign();
    int c0, e0;
    c0 = obs_cmd_n; e0 = obs_err_n;
    send_seq({8'h21, 8'h43, 8'h10, 8'h80, 8'hFF, 8'h52});
    settle();
    n_chk++; if (obs_cmd_n !== c0 || obs_err_n !== e0) begin n_err++; $display("FAIL foreign: got cmd %0d err %0d want 0 0", obs_cmd_n - c0, obs_err_n - e0); end
  endtask

  task automatic test_saturation();
    repeat (300) send_seq({8'h21, 8'h42, 8'h39});
    settle();
    n_chk++; if (err_count_out !== 8'd255 || m_count !== 255) begin n_err++; $display("FAIL saturation: got %0d want 255", err_count_out); end
    n_chk++; if (obs_err_n !== exp_err_n) begin n_err++; $display("FAIL saturation_pulses: got %0d want %0d", obs_err_n, exp_err_n); end
  endtask

  task automatic test_reset_mid();
    int e0;
    e0 = obs_err_n;
    send_seq({8'h21, 8'h42, 8'h36});
    do_reset(2);
    n_chk++; if (cmd_out !== 8'h00 || buttons_held_out !== 8'h00 || err_count_out !== 8'h00) begin n_err++; $display("FAIL midreset_outs: got %h %h %h want 00 00 00", cmd_out, buttons_held_out, err_count_out); end
    rst_in = 1'b0;
    send_seq({8'h31, 8'h37});
    settle();
    n_chk++; if (obs_err_n !== e0 || err_count_out !== 8'h00) begin n_err++; $display("FAIL midreset_noerr: got %0d want 0", obs_err_n - e0); end
    send_seq({8'h21, 8'h42, 8'h34, 8'h31, csum(8'h34, 8'h31)});
    settle();
    n_chk++; if (cmd_out !== 8'h84 || buttons_held_out !== 8'h08) begin n_err++; $display("FAIL midreset_next: got %h %h want 84 08", cmd_out, buttons_held_out); end
  endtask

  task automatic test_random();
    byte_q_t s;
    int kind, g;
    logic [7:0] btn, st;
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 3);
      btn = 8'h30 + 8'($urandom_range(1, 8));
      st = 8'h30 + 8'($urandom_range(0, 1));
      s = {8'h21, 8'h42, btn, st, csum(btn, st)};
      if (kind == 1) s[$urandom_range(0, 4)] = 8'($urandom_range(0, 255));
      else if (kind == 2) s = {8'($urandom_range(0, 255))};
      else if (kind == 3) s = {8'h21, 8'h43, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      send_seq(s);
      g = $urandom_range(0, 9);
      if (g == 7) idle($urandom_range(1, 3));
      else if (g == 8) idle(T - 1 + $urandom_range(0, 1));
      else if (g == 9) idle(T + 1);
      if (it % 15 == 14) begin
        settle();
        n_chk++; if (obs_cmd_n !== exp_cmd_n || obs_err_n !== exp_err_n) begin n_err++; $display("FAIL rand_pulses it%0d: got cmd %0d err %0d want %0d %0d", it, obs_cmd_n, obs_err_n, exp_cmd_n, exp_err_n); end
        n_chk++; if (cmd_out !== m_cmd || buttons_held_out !== m_held || err_count_out !== 8'(m_count)) begin n_err++; $display("FAIL rand_state it%0d: got %h %h %0d want %h %h %0d", it, cmd_out, buttons_held_out, err_count_out, m_cmd, m_held, m_count); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bad_checksum();
    test_resync();
    test_timeout();
    test_foreign();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
